// File: rtl/carus_sram_stream_reader.sv
// carus_sram_stream_reader
//
// Read-only initiator for a single Carus SRAM bank. After a start pulse it
// walks a contiguous, wrapping range of words in the bank and delivers them
// in order on a valid/ready stream. The bank returns data exactly one cycle
// after a request. A small FIFO absorbs that latency and any downstream
// stall. Requests are throttled by a credit check, so every word already in
// flight always has a FIFO slot waiting for it.
//
// Ports
//   clk_i, rst_ni           clock, asynchronous active-low reset
//   start_i                 start pulse, only honoured while idle
//   base_addr_i, len_i      first word and word count (0..NUM_WORDS),
//                           captured when a start is accepted
//   abort_i                 synchronous abort of a running transfer
//   busy_o, done_o          activity flag and one-cycle completion pulse
//   sram_*                  bank port (read-only: we=0, be=F, wdata=0)
//   sram_rdata_i            bank read data, one cycle after sram_req_o
//   data_o, valid_o, ready_i  output stream (data_o is the FIFO head)

module carus_sram_stream_reader #(
  parameter int  NUM_WORDS  = 1024,
  parameter int  FIFO_DEPTH = 2,
  localparam int AddrWidth  = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic [AddrWidth-1:0] base_addr_i,
  input  logic [AddrWidth:0]   len_i,
  input  logic                 abort_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 sram_req_o,
  output logic                 sram_we_o,
  output logic [AddrWidth-1:0] sram_addr_o,
  output logic [31:0]          sram_wdata_o,
  output logic [3:0]           sram_be_o,
  output logic                 sram_set_retentive_no,
  input  logic [31:0]          sram_rdata_i,
  output logic [31:0]          data_o,
  output logic                 valid_o,
  input  logic                 ready_i
);

  localparam int LenWidth  = AddrWidth + 1;
  localparam int PtrWidth  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CntWidth  = $clog2(FIFO_DEPTH + 1);
  localparam int UsedWidth = CntWidth + 1;

  localparam logic [AddrWidth-1:0] LastAddr  = AddrWidth'(NUM_WORDS - 1);
  localparam logic [PtrWidth-1:0]  LastPtr   = PtrWidth'(FIFO_DEPTH - 1);
  localparam logic [CntWidth-1:0]  DepthCnt  = CntWidth'(FIFO_DEPTH);
  localparam logic [UsedWidth-1:0] DepthUsed = UsedWidth'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [AddrWidth-1:0] addr_q, addr_d;
  logic [LenWidth-1:0]  to_issue_q, to_issue_d;
  logic [LenWidth-1:0]  to_pop_q, to_pop_d;
  logic                 done_q, done_d;
  logic                 inflight_q, inflight_d;

  logic [31:0]          fifo_mem_q [FIFO_DEPTH];
  logic [31:0]          fifo_mem_d [FIFO_DEPTH];
  logic [PtrWidth-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrWidth-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntWidth-1:0]  count_q, count_d;

  logic                 req;
  logic                 pop;
  logic                 push;
  logic                 flush;
  logic [UsedWidth-1:0] used;

  function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
    return (p == LastPtr) ? '0 : p + PtrWidth'(1);
  endfunction

  // Abort only matters once a transfer is running; in IDLE it is ignored so
  // a start arriving together with a stray abort still launches.
  assign flush = abort_i && (state_q != IDLE);
  assign pop   = valid_o && ready_i;
  // A response landing in the abort cycle belongs to the cancelled transfer.
  assign push  = inflight_q && !flush;

  // Slots committed for the next cycle: words held plus the word arriving,
  // minus the word leaving now. Issuing only while this is below the depth
  // means the response to a request made now can never overflow the FIFO.
  assign used = {1'b0, count_q} + UsedWidth'(inflight_q) - UsedWidth'(pop);

  // Control FSM: request issue, address walk, and completion detection.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    to_issue_d = to_issue_q;
    to_pop_d   = to_pop_q;
    done_d     = 1'b0;
    req        = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          if (len_i == '0) begin
            done_d = 1'b1;
          end else begin
            state_d    = RUN;
            addr_d     = base_addr_i;
            to_issue_d = len_i;
            to_pop_d   = len_i;
          end
        end
      end
      RUN: begin
        req = (to_issue_q != '0) && (used < DepthUsed);
        if (req) begin
          // The explicit wrap keeps the walk inside the bank even when
          // NUM_WORDS is not a power of two.
          addr_d     = (addr_q == LastAddr) ? '0 : addr_q + AddrWidth'(1);
          to_issue_d = to_issue_q - LenWidth'(1);
        end
        if ((to_issue_q == '0) || (req && (to_issue_q == LenWidth'(1)))) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if ((to_pop_q == '0) || (pop && (to_pop_q == LenWidth'(1)))) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (pop && (to_pop_q != '0)) begin
      to_pop_d = to_pop_q - LenWidth'(1);
    end

    if (flush) begin
      state_d    = IDLE;
      addr_d     = '0;
      to_issue_d = '0;
      to_pop_d   = '0;
      done_d     = 1'b0;
    end
  end

  // The bank answers every request one cycle later, so the in-flight flag is
  // simply the request delayed by a cycle.
  assign inflight_d = req && !flush;

  // Output FIFO: circular buffer with an occupancy count; push and pop may
  // coincide.
  always_comb begin
    fifo_mem_d = fifo_mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        fifo_mem_d[wr_ptr_q] = sram_rdata_i;
        wr_ptr_d             = ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      count_d = count_q + CntWidth'(push) - CntWidth'(pop);
    end
  end

  // State register for both the controller and the FIFO.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      to_issue_q <= '0;
      to_pop_q   <= '0;
      done_q     <= 1'b0;
      inflight_q <= 1'b0;
      fifo_mem_q <= '{default: '0};
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      to_issue_q <= to_issue_d;
      to_pop_q   <= to_pop_d;
      done_q     <= done_d;
      inflight_q <= inflight_d;
      fifo_mem_q <= fifo_mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  assign busy_o                = (state_q != IDLE);
  assign done_o                = done_q;
  assign sram_req_o            = req;
  assign sram_addr_o           = addr_q;
  assign sram_we_o             = 1'b0;
  assign sram_wdata_o          = 32'h0;
  assign sram_be_o             = 4'hF;
  assign sram_set_retentive_no = 1'b1;
  assign valid_o               = (count_q != '0);
  assign data_o                = fifo_mem_q[rd_ptr_q];

  // The credit check above should make this unreachable. A hit means the
  // issue throttle and the FIFO disagree about occupancy.
  no_overflow_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (push && !pop) |-> (count_q != DepthCnt));

endmodule

// File: tb/tb_carus_sram_stream_reader.sv
// Testbench for carus_sram_stream_reader. Includes a bank model with one
// cycle of read latency and a stream monitor. Expected words and addresses
// come from plain modulo arithmetic over the bench's own memory image.

module tb_carus_sram_stream_reader;

  localparam int NUM_WORDS   = 1024;
  localparam int FIFO_DEPTH  = 2;
  localparam int AW          = 10;
  localparam int LW          = AW + 1;
  localparam int MODE_HIGH   = 0;
  localparam int MODE_TOGGLE = 1;
  localparam int MODE_RAND   = 2;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          start_i;
  logic [AW-1:0] base_addr_i;
  logic [AW:0]   len_i;
  logic          abort_i;
  logic          busy_o;
  logic          done_o;
  logic          sram_req_o;
  logic          sram_we_o;
  logic [AW-1:0] sram_addr_o;
  logic [31:0]   sram_wdata_o;
  logic [3:0]    sram_be_o;
  logic          sram_set_retentive_no;
  logic [31:0]   sram_rdata_i;
  logic [31:0]   data_o;
  logic          valid_o;
  logic          ready_i;

  always #5 clk_i = ~clk_i;

  carus_sram_stream_reader #(
    .NUM_WORDS (NUM_WORDS),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk_i                (clk_i),
    .rst_ni               (rst_ni),
    .start_i              (start_i),
    .base_addr_i          (base_addr_i),
    .len_i                (len_i),
    .abort_i              (abort_i),
    .busy_o               (busy_o),
    .done_o               (done_o),
    .sram_req_o           (sram_req_o),
    .sram_we_o            (sram_we_o),
    .sram_addr_o          (sram_addr_o),
    .sram_wdata_o         (sram_wdata_o),
    .sram_be_o            (sram_be_o),
    .sram_set_retentive_no(sram_set_retentive_no),
    .sram_rdata_i         (sram_rdata_i),
    .data_o               (data_o),
    .valid_o              (valid_o),
    .ready_i              (ready_i)
  );

  // Bank model: the data is valid exactly one cycle after a request, and the
  // read port carries garbage in every other cycle.
  logic [31:0] mem [NUM_WORDS];
  always @(posedge clk_i) begin
    sram_rdata_i <= sram_req_o ? mem[sram_addr_o] : 32'hDEAD_BEEF;
  end

  int total = 0;
  int bad   = 0;

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s: actual=%0d required=%0d", name, actual, expected);
    end
  endtask

  // Stream monitor. It samples at the falling edge, records handshakes,
  // requests and done pulses, and checks that data is held while stalled and
  // that outstanding words never exceed the buffer depth.
  int          cyc = 0;
  logic [31:0] got_q[$];
  logic [AW-1:0] req_q[$];
  int          done_cnt, done_cyc, start_cyc, first_valid_cyc, last_hs_cyc;
  int          issued = 0, popped = 0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_data;
  logic        busy_seen;

  always @(negedge clk_i) begin
    cyc++;
    if (!rst_ni) begin
      issued     = 0;
      popped     = 0;
      prev_stall = 1'b0;
    end else begin
      if (busy_o) begin
        checkOutput("outstanding<=depth", longint'(issued - popped <= FIFO_DEPTH), 1);
        busy_seen = 1'b1;
      end
      if (prev_stall) begin
        checkOutput("stall holds valid", longint'(valid_o), 1);
        checkOutput("stall holds data", longint'(data_o), longint'(prev_data));
      end
      if (start_i && !busy_o) start_cyc = cyc;
      if (valid_o && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (valid_o && ready_i) begin
        got_q.push_back(data_o);
        popped++;
        last_hs_cyc = cyc;
      end
      if (sram_req_o) begin
        req_q.push_back(sram_addr_o);
        issued++;
      end
      if (done_o) begin
        done_cnt++;
        done_cyc = cyc;
      end
      prev_stall = valid_o && !ready_i && !abort_i;
      prev_data  = data_o;
      if (abort_i && busy_o) begin
        issued = 0;
        popped = 0;
      end
    end
  end

  function automatic logic pickReady(input int mode, input int k);
    case (mode)
      MODE_HIGH:   return 1'b1;
      MODE_TOGGLE: return (k % 3 == 0);
      default:     return 1'($urandom_range(0, 1));
    endcase
  endfunction

  task automatic clearMonitor();
    got_q.delete();
    req_q.delete();
    done_cnt        = 0;
    done_cyc        = -1;
    start_cyc       = -1;
    first_valid_cyc = -1;
    last_hs_cyc     = -1;
    busy_seen       = 1'b0;
  endtask

  // Runs one read of len words from base and checks it against the model.
  // Call it just after a rising edge. If poke >= 0, a bogus start is driven
  // that many cycles after the real one. abort_st raises abort together with
  // the start, while the block is still idle.
  task automatic applyStimulus(input string tag, input int base, input int len, input int mode,
                               input int exp_lat, input int exp_first, input int poke,
                               input logic abort_st);
    logic [31:0]   exp_data[$];
    logic [AW-1:0] exp_addr[$];
    int            budget, k, data_errs, addr_errs, n;
    for (int i = 0; i < len; i++) begin
      exp_data.push_back(mem[(base + i) % NUM_WORDS]);
      exp_addr.push_back(AW'((base + i) % NUM_WORDS));
    end
    clearMonitor();
    start_i     = 1'b1;
    base_addr_i = AW'(base);
    len_i       = LW'(len);
    abort_i     = abort_st;
    ready_i     = pickReady(mode, 0);
    @(posedge clk_i); #1;
    start_i     = 1'b0;
    abort_i     = 1'b0;
    base_addr_i = AW'($urandom);
    len_i       = LW'($urandom);
    k           = 1;
    budget      = 8 * len + 20;
    while (done_cnt == 0 && budget > 0) begin
      ready_i = pickReady(mode, k);
      start_i = (k == poke);
      k++;
      budget--;
      @(posedge clk_i); #1;
    end
    start_i = 1'b0;
    checkOutput({tag, " done within budget"}, longint'(done_cnt != 0), 1);
    ready_i = 1'b1;
    @(posedge clk_i); #1;
    checkOutput({tag, " done pulses"}, done_cnt, 1);
    checkOutput({tag, " busy after"}, longint'(busy_o), 0);
    checkOutput({tag, " valid after"}, longint'(valid_o), 0);
    checkOutput({tag, " word count"}, got_q.size(), len);
    checkOutput({tag, " request count"}, req_q.size(), len);
    data_errs = 0;
    addr_errs = 0;
    n = (got_q.size() < len) ? got_q.size() : len;
    for (int i = 0; i < n; i++) if (got_q[i] !== exp_data[i]) data_errs++;
    n = (req_q.size() < len) ? req_q.size() : len;
    for (int i = 0; i < n; i++) if (req_q[i] !== exp_addr[i]) addr_errs++;
    checkOutput({tag, " data errors"}, data_errs, 0);
    checkOutput({tag, " address errors"}, addr_errs, 0);
    if (exp_lat >= 0) checkOutput({tag, " start-to-done"}, done_cyc - start_cyc, exp_lat);
    checkOutput({tag, " first valid"},
                (first_valid_cyc < 0) ? -1 : first_valid_cyc - start_cyc, exp_first);
    checkOutput({tag, " busy seen"}, longint'(busy_seen), longint'(len > 0));
    if (len > 0) begin
      checkOutput({tag, " done after last word"}, done_cyc - last_hs_cyc, 1);
      checkOutput({tag, " final address"}, longint'(sram_addr_o), (base + len) % NUM_WORDS);
    end
  endtask

  typedef struct {
    string name;
    int    base;
    int    len;
    int    mode;
    int    exp_lat;
    int    exp_first;
    int    poke;
    logic  abort_st;
  } vec_t;

  vec_t vecs [10];

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base, len, mode;

    // With ready held high, the first word is visible 3 sampled cycles after
    // the start cycle and done arrives at len+3 (one cycle after the last
    // handshake). With len=0, done arrives in the next cycle.
    vecs[0] = '{"basic",      10,        4,         MODE_HIGH,   7,    3,  -1, 1'b0};
    vecs[1] = '{"wrap",       1022,      4,         MODE_HIGH,   7,    3,  -1, 1'b0};
    vecs[2] = '{"backpress",  100,       8,         MODE_TOGGLE, -1,   3,  -1, 1'b0};
    vecs[3] = '{"len0",       0,         0,         MODE_HIGH,   1,    -1, -1, 1'b0};
    vecs[4] = '{"single",     1023,      1,         MODE_HIGH,   4,    3,  -1, 1'b0};
    vecs[5] = '{"fullbank",   5,         NUM_WORDS, MODE_HIGH,   1027, 3,  -1, 1'b0};
    vecs[6] = '{"randready",  700,       20,        MODE_RAND,   -1,   3,  -1, 1'b0};
    vecs[7] = '{"toggle2",    512,       2,         MODE_TOGGLE, -1,   3,  -1, 1'b0};
    vecs[8] = '{"restart",    50,        6,         MODE_HIGH,   9,    3,  2,  1'b0};
    vecs[9] = '{"idleabort",  200,       3,         MODE_HIGH,   6,    3,  -1, 1'b1};

    for (int i = 0; i < NUM_WORDS; i++) mem[i] = 32'(i);
    rst_ni      = 1'b0;
    start_i     = 1'b0;
    abort_i     = 1'b0;
    ready_i     = 1'b1;
    base_addr_i = '0;
    len_i       = '0;
    clearMonitor();

    repeat (3) @(posedge clk_i);
    #1;
    checkOutput("reset busy", longint'(busy_o), 0);
    checkOutput("reset done", longint'(done_o), 0);
    checkOutput("reset req", longint'(sram_req_o), 0);
    checkOutput("reset addr", longint'(sram_addr_o), 0);
    checkOutput("reset valid", longint'(valid_o), 0);
    checkOutput("reset data", longint'(data_o), 0);
    checkOutput("const we", longint'(sram_we_o), 0);
    checkOutput("const wdata", longint'(sram_wdata_o), 0);
    checkOutput("const be", longint'(sram_be_o), 15);
    checkOutput("const retentive", longint'(sram_set_retentive_no), 1);
    rst_ni = 1'b1;
    @(posedge clk_i); #1;

    for (int v = 0; v < 10; v++) begin
      applyStimulus(vecs[v].name, vecs[v].base, vecs[v].len, vecs[v].mode, vecs[v].exp_lat,
                    vecs[v].exp_first, vecs[v].poke, vecs[v].abort_st);
    end

    // Abort three cycles into a stalled 16-word read. FIFO holds stale words
    // and a response is in flight at the abort edge.
    clearMonitor();
    start_i     = 1'b1;
    base_addr_i = AW'(300);
    len_i       = LW'(16);
    ready_i     = 1'b0;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    abort_i = 1'b1;
    @(posedge clk_i); #1;
    abort_i = 1'b0;
    checkOutput("abort busy", longint'(busy_o), 0);
    checkOutput("abort valid", longint'(valid_o), 0);
    checkOutput("abort req", longint'(sram_req_o), 0);
    req_q.delete();
    ready_i = 1'b1;
    repeat (4) @(posedge clk_i);
    #1;
    checkOutput("abort no done", done_cnt, 0);
    checkOutput("abort no words", got_q.size(), 0);
    checkOutput("abort no requests", req_q.size(), 0);
    applyStimulus("after abort", 0, 2, MODE_HIGH, 5, 3, -1, 1'b0);

    // Asynchronous reset in the middle of a read.
    clearMonitor();
    start_i     = 1'b1;
    base_addr_i = AW'(10);
    len_i       = LW'(16);
    ready_i     = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    repeat (4) @(posedge clk_i);
    #2;
    rst_ni = 1'b0;
    #1;
    checkOutput("midreset busy", longint'(busy_o), 0);
    checkOutput("midreset req", longint'(sram_req_o), 0);
    checkOutput("midreset valid", longint'(valid_o), 0);
    checkOutput("midreset data", longint'(data_o), 0);
    checkOutput("midreset done", longint'(done_o), 0);
    checkOutput("midreset addr", longint'(sram_addr_o), 0);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
    applyStimulus("after reset", 10, 4, MODE_HIGH, 7, 3, -1, 1'b0);

    // Random reads over a random memory image.
    for (int i = 0; i < NUM_WORDS; i++) mem[i] = $urandom;
    for (int r = 0; r < 20; r++) begin
      base = $urandom_range(0, NUM_WORDS - 1);
      len  = $urandom_range(1, 40);
      mode = $urandom_range(0, 2);
      applyStimulus($sformatf("rand%0d", r), base, len, mode,
                    (mode == MODE_HIGH) ? len + 3 : -1, 3, -1, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
